// File: rtl/match_pkg.sv
// Shared types and constants for the multi-round match controller.
// Pure declarations, so there is no latency and no backpressure here.
// The link byte layout is [7] start, [6] done, [5:0] score.
package match_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_ROUND      = 3'd2,
    ST_WAIT_END   = 3'd3,
    ST_INTER      = 3'd4,
    ST_MATCH_END  = 3'd5
  } match_state_t;

  localparam logic [1:0] WIN_TIE  = 2'b00;
  localparam logic [1:0] WIN_WIN  = 2'b01;
  localparam logic [1:0] WIN_LOSS = 2'b10;

  localparam int LINK_START_BIT = 7;
  localparam int LINK_DONE_BIT  = 6;

  localparam int DEF_ROUNDS           = 3;
  localparam int DEF_SCORE_WIDTH      = 6;
  localparam int DEF_INTER_CYCLES     = 65_000_000;
  localparam int DEF_KEEPALIVE_CYCLES = 16_250_000;
  localparam int DEF_LINK_TIMEOUT     = 130_000_000;

  // One-hot enables: {match_end, inter, wait_end, round, wait_start, start_screen}
  function automatic logic [5:0] state_onehot(input match_state_t s);
    logic [5:0] v;
    v = 6'b000000;
    case (s)
      ST_IDLE:       v = 6'b000001;
      ST_WAIT_START: v = 6'b000010;
      ST_ROUND:      v = 6'b000100;
      ST_WAIT_END:   v = 6'b001000;
      ST_INTER:      v = 6'b010000;
      ST_MATCH_END:  v = 6'b100000;
      default:       v = 6'b000001;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] link_byte(input logic start, input logic done,
                                           input logic [5:0] score);
    logic [7:0] b;
    b = 8'h00;
    b[5:0] = score;
    b[LINK_START_BIT] = start;
    b[LINK_DONE_BIT]  = done;
    return b;
  endfunction

endpackage

// File: rtl/link_tx_ctl.sv
// Holds the outgoing link byte and raises valid whenever it changes or the keepalive period elapses.
// Latency: a change on i_byte appears on o_data/o_valid one cycle later.
// Backpressure: valid is held until i_ready; a newer byte overwrites a pending one in place.
module link_tx_ctl
  import match_pkg::*;
#(
  parameter int KEEPALIVE_CYCLES = DEF_KEEPALIVE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid
);

  localparam logic [31:0] KA_LAST = 32'(KEEPALIVE_CYCLES - 1);

  logic [7:0]  r_data;
  logic        r_valid;
  logic [31:0] r_ka;
  logic        w_change;
  logic        w_ka_fire;

  assign w_change  = (i_byte != r_data);
  assign w_ka_fire = (r_ka >= KA_LAST);

  // Byte register, valid handshake and keepalive resend timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ka    <= 32'd0;
    end else if (w_change) begin
      r_data  <= i_byte;
      r_valid <= 1'b1;
      r_ka    <= 32'd0;
    end else if (w_ka_fire) begin
      r_valid <= 1'b1;
      r_ka    <= 32'd0;
    end else begin
      r_ka <= r_ka + 32'd1;
      if (r_valid && i_ready) r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/match_ctl.sv
// Multi-round Duck Hunt match sequencer with link status exchange, scoring and optional rx watchdog (LINK_TIMEOUT_EN).
// Latency: all outputs registered; state enables move one cycle after the triggering input.
// Backpressure: tx byte waits on link_tx_ready with latest-wins update; rx is a strobe and is never stalled.
module match_ctl
  import match_pkg::*;
#(
  parameter int ROUNDS           = DEF_ROUNDS,
  parameter int SCORE_WIDTH      = DEF_SCORE_WIDTH,
  parameter int INTER_CYCLES     = DEF_INTER_CYCLES,
  parameter int KEEPALIVE_CYCLES = DEF_KEEPALIVE_CYCLES,
  parameter int LINK_TIMEOUT     = DEF_LINK_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_req,
  input  logic                   round_done,
  input  logic [SCORE_WIDTH-1:0] my_round_score,
  input  logic [7:0]             link_rx_data,
  input  logic                   link_rx_valid,
  output logic [7:0]             link_tx_data,
  output logic                   link_tx_valid,
  input  logic                   link_tx_ready,
  output logic                   start_screen_en,
  output logic                   wait_start_en,
  output logic                   round_en,
  output logic                   wait_end_en,
  output logic                   inter_en,
  output logic                   match_end_en,
  output logic                   round_start,
  output logic [3:0]             round_idx,
  output logic [SCORE_WIDTH+3:0] my_total,
  output logic [SCORE_WIDTH+3:0] enemy_total,
  output logic [3:0]             my_wins,
  output logic [3:0]             enemy_wins,
  output logic [1:0]             winner_status,
  output logic                   link_lost
);

  localparam int          TW         = SCORE_WIDTH + 4;
  localparam logic [31:0] INTER_LAST = 32'(INTER_CYCLES);

  if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
    $error("match_ctl: ROUNDS must be in 1..15");
  end
  if (SCORE_WIDTH < 1 || SCORE_WIDTH > 6) begin : g_bad_score_width
    $error("match_ctl: SCORE_WIDTH must be in 1..6");
  end
  if (LINK_TIMEOUT <= KEEPALIVE_CYCLES) begin : g_bad_timeout
    $error("match_ctl: LINK_TIMEOUT must exceed KEEPALIVE_CYCLES");
  end

  match_state_t           r_state;
  logic [5:0]             r_en;
  logic                   r_round_start;
  logic [3:0]             r_round_idx;
  logic [TW-1:0]          r_my_total;
  logic [TW-1:0]          r_en_total;
  logic [3:0]             r_my_wins;
  logic [3:0]             r_en_wins;
  logic [1:0]             r_winner;
  logic [SCORE_WIDTH-1:0] r_my_score;
  logic [31:0]            r_inter_cnt;
  logic [7:0]             r_rx;

  logic [7:0]             w_rx;
  logic                   w_rx_start;
  logic                   w_rx_done;
  logic [SCORE_WIDTH-1:0] w_en_score;
  logic [TW:0]            w_my_sum;
  logic [TW:0]            w_en_sum;
  logic [TW-1:0]          w_my_total_nxt;
  logic [TW-1:0]          w_en_total_nxt;
  logic [3:0]             w_my_wins_nxt;
  logic [3:0]             w_en_wins_nxt;
  logic                   w_match_over;
  logic [5:0]             w_tot_sat;
  logic [7:0]             w_tx_byte;
  logic                   w_wd_fire;

  // A byte arriving this cycle is visible immediately so decisions take one cycle
  assign w_rx       = link_rx_valid ? link_rx_data : r_rx;
  assign w_rx_start = w_rx[LINK_START_BIT];
  assign w_rx_done  = w_rx[LINK_DONE_BIT];
  assign w_en_score = w_rx[SCORE_WIDTH-1:0];

  assign w_my_sum = {1'b0, r_my_total} + {{(TW+1-SCORE_WIDTH){1'b0}}, r_my_score};
  assign w_en_sum = {1'b0, r_en_total} + {{(TW+1-SCORE_WIDTH){1'b0}}, w_en_score};
  assign w_my_total_nxt = w_my_sum[TW] ? {TW{1'b1}} : w_my_sum[TW-1:0];
  assign w_en_total_nxt = w_en_sum[TW] ? {TW{1'b1}} : w_en_sum[TW-1:0];

  assign w_my_wins_nxt = (r_my_score > w_en_score && r_my_wins != 4'hF) ? r_my_wins + 4'd1 : r_my_wins;
  assign w_en_wins_nxt = (w_en_score > r_my_score && r_en_wins != 4'hF) ? r_en_wins + 4'd1 : r_en_wins;

  // Last round played, or one side already holds a majority of the rounds
  assign w_match_over = (r_round_idx == 4'(ROUNDS - 1)) ||
                        (w_my_wins_nxt > 4'(ROUNDS / 2)) ||
                        (w_en_wins_nxt > 4'(ROUNDS / 2));

  assign w_tot_sat = (r_my_total > TW'(63)) ? 6'h3F : 6'(r_my_total);

  function automatic logic [1:0] f_winner(input logic [3:0] mw, input logic [3:0] ew,
                                          input logic [TW-1:0] mt, input logic [TW-1:0] et);
    logic [1:0] w;
    if (mw > ew)      w = WIN_WIN;
    else if (ew > mw) w = WIN_LOSS;
    else if (mt > et) w = WIN_WIN;
    else if (et > mt) w = WIN_LOSS;
    else              w = WIN_TIE;
    return w;
  endfunction

  // Latch every enemy status byte regardless of state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx <= 8'h00;
    else if (link_rx_valid) r_rx <= link_rx_data;
  end

  // Local status byte as a function of the current state
  always_comb begin
    w_tx_byte = 8'h00;
    case (r_state)
      ST_WAIT_START: w_tx_byte = link_byte(1'b1, 1'b0, 6'd0);
      ST_ROUND:      w_tx_byte = link_byte(1'b1, 1'b0, 6'(my_round_score));
      ST_WAIT_END:   w_tx_byte = link_byte(1'b1, 1'b1, 6'(r_my_score));
      ST_MATCH_END:  w_tx_byte = link_byte(1'b0, 1'b1, w_tot_sat);
      default:       w_tx_byte = 8'h00;
    endcase
  end

`ifdef LINK_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(LINK_TIMEOUT - 1);

  logic [31:0] r_wd_cnt;
  logic        r_link_lost;
  logic        w_wd_active;

  assign w_wd_active = (r_state == ST_WAIT_START) || (r_state == ST_ROUND) ||
                       (r_state == ST_WAIT_END)   || (r_state == ST_INTER);
  assign w_wd_fire   = w_wd_active && !link_rx_valid && (r_wd_cnt >= WD_LAST);

  // Count silent cycles while the link is expected to be alive; sticky loss flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt    <= 32'd0;
      r_link_lost <= 1'b0;
    end else begin
      if (!w_wd_active || link_rx_valid) r_wd_cnt <= 32'd0;
      else if (!w_wd_fire)               r_wd_cnt <= r_wd_cnt + 32'd1;
      if (w_wd_fire)                                r_link_lost <= 1'b1;
      else if (r_state == ST_IDLE && start_req)     r_link_lost <= 1'b0;
    end
  end

  assign link_lost = r_link_lost;
`else
  assign w_wd_fire = 1'b0;
  assign link_lost = 1'b0;
`endif

  // Match sequencer with registered enables, scoring and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_en          <= state_onehot(ST_IDLE);
      r_round_start <= 1'b0;
      r_round_idx   <= 4'd0;
      r_my_total    <= '0;
      r_en_total    <= '0;
      r_my_wins     <= 4'd0;
      r_en_wins     <= 4'd0;
      r_winner      <= WIN_TIE;
      r_my_score    <= '0;
      r_inter_cnt   <= 32'd0;
    end else begin
      r_round_start <= 1'b0;
      if (w_wd_fire) begin
        r_state  <= ST_MATCH_END;
        r_en     <= state_onehot(ST_MATCH_END);
        r_winner <= f_winner(r_my_wins, r_en_wins, r_my_total, r_en_total);
      end else begin
        case (r_state)
          ST_IDLE: if (start_req) begin
            r_state     <= ST_WAIT_START;
            r_en        <= state_onehot(ST_WAIT_START);
            r_round_idx <= 4'd0;
            r_my_total  <= '0;
            r_en_total  <= '0;
            r_my_wins   <= 4'd0;
            r_en_wins   <= 4'd0;
            r_winner    <= WIN_TIE;
          end
          ST_WAIT_START: if (w_rx_start && !w_rx_done) begin
            r_state       <= ST_ROUND;
            r_en          <= state_onehot(ST_ROUND);
            r_round_start <= 1'b1;
          end
          ST_ROUND: if (round_done) begin
            r_state    <= ST_WAIT_END;
            r_en       <= state_onehot(ST_WAIT_END);
            r_my_score <= my_round_score;
          end
          ST_WAIT_END: if (w_rx_done) begin
            r_my_total <= w_my_total_nxt;
            r_en_total <= w_en_total_nxt;
            r_my_wins  <= w_my_wins_nxt;
            r_en_wins  <= w_en_wins_nxt;
            if (w_match_over) begin
              r_state  <= ST_MATCH_END;
              r_en     <= state_onehot(ST_MATCH_END);
              r_winner <= f_winner(w_my_wins_nxt, w_en_wins_nxt, w_my_total_nxt, w_en_total_nxt);
            end else begin
              r_state     <= ST_INTER;
              r_en        <= state_onehot(ST_INTER);
              r_inter_cnt <= 32'd0;
            end
          end
          ST_INTER: begin
            if (r_inter_cnt >= INTER_LAST && !w_rx_start && !w_rx_done) begin
              r_state     <= ST_WAIT_START;
              r_en        <= state_onehot(ST_WAIT_START);
              r_round_idx <= (r_round_idx != 4'hF) ? r_round_idx + 4'd1 : r_round_idx;
            end else if (r_inter_cnt < INTER_LAST) begin
              r_inter_cnt <= r_inter_cnt + 32'd1;
            end
          end
          ST_MATCH_END: if (start_req) begin
            r_state <= ST_IDLE;
            r_en    <= state_onehot(ST_IDLE);
          end
          default: begin
            r_state <= ST_IDLE;
            r_en    <= state_onehot(ST_IDLE);
          end
        endcase
      end
    end
  end

  link_tx_ctl #(
    .KEEPALIVE_CYCLES(KEEPALIVE_CYCLES)
  ) u_link_tx (
    .clk    (clk),
    .rst    (rst),
    .i_byte (w_tx_byte),
    .i_ready(link_tx_ready),
    .o_data (link_tx_data),
    .o_valid(link_tx_valid)
  );

  assign start_screen_en = r_en[0];
  assign wait_start_en   = r_en[1];
  assign round_en        = r_en[2];
  assign wait_end_en     = r_en[3];
  assign inter_en        = r_en[4];
  assign match_end_en    = r_en[5];
  assign round_start     = r_round_start;
  assign round_idx       = r_round_idx;
  assign my_total        = r_my_total;
  assign enemy_total     = r_en_total;
  assign my_wins         = r_my_wins;
  assign enemy_wins      = r_en_wins;
  assign winner_status   = r_winner;

endmodule

// File: tb/tb_match_ctl.sv
// Bench for match_ctl: table-driven matches against a scripted enemy board, plus
// hand-written sequences for tx backpressure, keepalive, async reset and the link watchdog.
module tb_match_ctl;

  localparam int ROUNDS  = 3;
  localparam int SW      = 6;
  localparam int INTER   = 20;
  localparam int KA      = 400;
  localparam int TIMEOUT = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_req = 1'b0;
  logic          round_done = 1'b0;
  logic [SW-1:0] my_round_score = '0;
  logic [7:0]    link_rx_data = 8'h00;
  logic          link_rx_valid = 1'b0;
  logic [7:0]    link_tx_data;
  logic          link_tx_valid;
  logic          link_tx_ready = 1'b1;
  logic          start_screen_en, wait_start_en, round_en, wait_end_en, inter_en, match_end_en;
  logic          round_start;
  logic [3:0]    round_idx;
  logic [SW+3:0] my_total, enemy_total;
  logic [3:0]    my_wins, enemy_wins;
  logic [1:0]    winner_status;
  logic          link_lost;
  logic [5:0]    en_vec;

  assign en_vec = {match_end_en, inter_en, wait_end_en, round_en, wait_start_en, start_screen_en};

  match_ctl #(
    .ROUNDS(ROUNDS), .SCORE_WIDTH(SW), .INTER_CYCLES(INTER),
    .KEEPALIVE_CYCLES(KA), .LINK_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .round_done(round_done),
    .my_round_score(my_round_score), .link_rx_data(link_rx_data), .link_rx_valid(link_rx_valid),
    .link_tx_data(link_tx_data), .link_tx_valid(link_tx_valid), .link_tx_ready(link_tx_ready),
    .start_screen_en(start_screen_en), .wait_start_en(wait_start_en), .round_en(round_en),
    .wait_end_en(wait_end_en), .inter_en(inter_en), .match_end_en(match_end_en),
    .round_start(round_start), .round_idx(round_idx), .my_total(my_total),
    .enemy_total(enemy_total), .my_wins(my_wins), .enemy_wins(enemy_wins),
    .winner_status(winner_status), .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mw;
    logic [3:0] ew;
    logic [9:0] mt;
    logic [9:0] et;
  } res_t;

  typedef struct {
    int         rnd;
    logic [5:0] my_sc;
    logic [5:0] en_sc;
    logic [3:0] e_mw;
    logic [3:0] e_ew;
    logic [9:0] e_mt;
    logic [9:0] e_et;
    bit         e_end;
    logic [1:0] e_win;
  } row_t;

  res_t exp_q[$];
  res_t act_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rs = 0;
  int   n_xfer = 0;
  logic prev_we = 1'b0;

  // Observer: captures scoring results when WAIT_END exits, counts pulses and tx transfers
  always @(negedge clk) begin
    if (prev_we && !wait_end_en) act_q.push_back('{my_wins, enemy_wins, my_total, enemy_total});
    if (round_start) n_rs++;
    if (link_tx_valid && link_tx_ready) n_xfer++;
    prev_we = wait_end_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_en(input int b, input string name, input int max_cyc);
    int k;
    k = 0;
    while (!en_vec[b] && k < max_cyc) begin
      tick();
      k++;
    end
    n_checks++;
    if (!en_vec[b]) begin
      n_errors++;
      $display("FAIL %s: enable not seen within %0d cycles, enables=0x%0h", name, max_cyc, en_vec);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    link_rx_data  = b;
    link_rx_valid = 1'b1;
    tick();
    link_rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
  endtask

  task automatic check_round(input string name);
    res_t e;
    res_t a;
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0 || act_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard underflow, expected entries %0d, observed entries %0d",
               name, exp_q.size(), act_q.size());
    end else begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      chk({name, " my_wins"}, 32'(a.mw), 32'(e.mw));
      chk({name, " enemy_wins"}, 32'(a.ew), 32'(e.ew));
      chk({name, " my_total"}, 32'(a.mt), 32'(e.mt));
      chk({name, " enemy_total"}, 32'(a.et), 32'(e.et));
    end
  endtask

  // Drive one round as the enemy board; returns once WAIT_END has been entered
  task automatic play_round(input row_t r, input string name);
    wait_en(1, {name, " wait_start"}, 300);
    send_rx(8'h80);
    chk({name, " round_en"}, 32'(round_en), 32'd1);
    chk({name, " round_start first cycle"}, 32'(round_start), 32'd1);
    chk({name, " round_idx"}, 32'(round_idx), 32'(r.rnd));
    my_round_score = r.my_sc;
    send_rx({2'b11, r.en_sc});
    chk({name, " round_start second cycle"}, 32'(round_start), 32'd0);
    exp_q.push_back('{r.e_mw, r.e_ew, r.e_mt, r.e_et});
    round_done = 1'b1;
    tick();
    round_done = 1'b0;
    chk({name, " wait_end_en"}, 32'(wait_end_en), 32'd1);
  endtask

  row_t tbl[8];

  initial begin : main
    int rs_base;
    int xf_base;
    int k;
    string nm;

    // {round, my score, enemy score, exp my_wins, enemy_wins, my_total, enemy_total, match ends, winner}
    tbl[0] = '{0, 6'd5, 6'd3, 4'd1, 4'd0, 10'd5,  10'd3,  1'b0, 2'b00};
    tbl[1] = '{1, 6'd2, 6'd4, 4'd1, 4'd1, 10'd7,  10'd7,  1'b0, 2'b00};
    tbl[2] = '{2, 6'd4, 6'd1, 4'd2, 4'd1, 10'd11, 10'd8,  1'b1, 2'b01};
    tbl[3] = '{0, 6'd6, 6'd1, 4'd1, 4'd0, 10'd6,  10'd1,  1'b0, 2'b00};
    tbl[4] = '{1, 6'd3, 6'd2, 4'd2, 4'd0, 10'd9,  10'd3,  1'b1, 2'b01};
    tbl[5] = '{0, 6'd5, 6'd2, 4'd1, 4'd0, 10'd5,  10'd2,  1'b0, 2'b00};
    tbl[6] = '{1, 6'd4, 6'd4, 4'd1, 4'd0, 10'd9,  10'd6,  1'b0, 2'b00};
    tbl[7] = '{2, 6'd0, 6'd6, 4'd1, 4'd1, 10'd9,  10'd12, 1'b1, 2'b10};

    // Reset state
    tick();
    tick();
    chk("reset enables", 32'(en_vec), 32'h01);
    chk("reset tx_data", 32'(link_tx_data), 32'h00);
    chk("reset tx_valid", 32'(link_tx_valid), 32'd0);
    chk("reset winner", 32'(winner_status), 32'd0);
    chk("reset link_lost", 32'(link_lost), 32'd0);
    chk("reset round_start", 32'(round_start), 32'd0);
    chk("reset round_idx", 32'(round_idx), 32'd0);
    chk("reset totals", 32'({my_total, enemy_total}), 32'd0);
    chk("reset wins", 32'({my_wins, enemy_wins}), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle holds without start", 32'(en_vec), 32'h01);

    // Table-driven matches
    rs_base = 0;
    for (int i = 0; i < 8; i++) begin
      nm = $sformatf("row%0d", i);
      if (tbl[i].rnd == 0) begin
        if (match_end_en) pulse_start();
        pulse_start();
        chk({nm, " match start totals cleared"}, 32'({my_total, enemy_total, my_wins, enemy_wins}), 32'd0);
        rs_base = n_rs;
      end
      play_round(tbl[i], nm);
      if (tbl[i].e_end) begin
        wait_en(5, {nm, " match_end"}, 10);
        chk({nm, " winner_status"}, 32'(winner_status), 32'(tbl[i].e_win));
        chk({nm, " final round_idx"}, 32'(round_idx), 32'(tbl[i].rnd));
        chk({nm, " link_lost"}, 32'(link_lost), 32'd0);
        check_round(nm);
        tick();
        tick();
        chk({nm, " match_end tx byte"}, 32'(link_tx_data), 32'(8'h40 | 8'(tbl[i].e_mt)));
        for (int j = 0; j < 30; j++) tick();
        chk({nm, " stays in match_end"}, 32'(en_vec), 32'h20);
        chk({nm, " round_start count"}, 32'(n_rs - rs_base), 32'(tbl[i].rnd + 1));
      end else begin
        wait_en(4, {nm, " inter"}, 10);
        check_round(nm);
        send_rx(8'h00);
      end
    end

    // Tx backpressure: byte changes twice while ready is low
    pulse_start();
    for (int j = 0; j < 4; j++) tick();
    link_tx_ready = 1'b0;
    xf_base = n_xfer;
    my_round_score = 6'd7;
    pulse_start();
    send_rx(8'h80);
    for (int j = 0; j < 3; j++) tick();
    chk("stall valid held", 32'(link_tx_valid), 32'd1);
    chk("stall latest data", 32'(link_tx_data), 32'h87);
    chk("stall no transfer", 32'(n_xfer - xf_base), 32'd0);
    link_tx_ready = 1'b1;
    tick();
    link_tx_ready = 1'b0;
    chk("valid drops after handshake", 32'(link_tx_valid), 32'd0);
    tick();
    tick();
    chk("single transfer", 32'(n_xfer - xf_base), 32'd1);
    k = 0;
    while (!link_tx_valid && k < KA + 20) begin
      tick();
      k++;
    end
    chk("keepalive raised valid", 32'(link_tx_valid), 32'd1);
    chk("keepalive data unchanged", 32'(link_tx_data), 32'h87);

    // Score one round, then reset asynchronously in the middle of the next ROUND
    round_done = 1'b1;
    tick();
    round_done = 1'b0;
    exp_q.push_back('{4'd1, 4'd0, 10'd7, 10'd3});
    send_rx(8'hC3);
    wait_en(4, "pre-reset inter", 10);
    check_round("pre-reset round");
    send_rx(8'h00);
    wait_en(1, "pre-reset wait_start", 300);
    my_round_score = 6'd9;
    send_rx(8'h80);
    tick();
    chk("pre-reset round_en", 32'(round_en), 32'd1);
    chk("pre-reset my_total", 32'(my_total), 32'd7);
    chk("pre-reset tx_valid", 32'(link_tx_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async reset enables", 32'(en_vec), 32'h01);
    chk("async reset totals", 32'({my_total, enemy_total}), 32'd0);
    chk("async reset tx_valid", 32'(link_tx_valid), 32'd0);
    tick();
    rst = 1'b0;
    link_tx_ready = 1'b1;
    tick();

    // Link silence in ROUND
    pulse_start();
    send_rx(8'h80);
    chk("silence round entered", 32'(round_en), 32'd1);
`ifdef LINK_TIMEOUT_EN
    for (int j = 0; j < TIMEOUT - 1; j++) tick();
    chk("watchdog not yet fired", 32'(match_end_en), 32'd0);
    chk("link_lost not yet set", 32'(link_lost), 32'd0);
    tick();
    chk("watchdog match_end", 32'(match_end_en), 32'd1);
    chk("watchdog link_lost", 32'(link_lost), 32'd1);
    chk("watchdog winner", 32'(winner_status), 32'd0);
    chk("watchdog no scoring", 32'({my_total, enemy_total}), 32'd0);
`else
    for (int j = 0; j < TIMEOUT + 100; j++) tick();
    chk("no watchdog still in round", 32'(round_en), 32'd1);
    chk("no watchdog link_lost", 32'(link_lost), 32'd0);
`endif

    chk("scoreboard expected drained", 32'(exp_q.size()), 32'd0);
    chk("scoreboard observed drained", 32'(act_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: simulation did not complete within 50000 cycles");
    $fatal(1);
  end

endmodule
